video_fifo: RTL



---
 rtl/video_fifo_pkg.sv | 21 ++
 rtl/video_fifo_ram.sv | 43 ++++
 rtl/video_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/video_fifo_pkg.sv
// Shared constants, types and helpers for the video_fifo block.
// The optional almost-full / almost-empty flags are controlled by the
// VIDEO_FIFO_ALMOST_EN macro; see video_fifo.sv.
package video_fifo_pkg;

    // Default geometry: 256 words of 8 bits.
    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAeThresh  = 4;
    localparam int unsigned DefAfThresh  = (1 << DefAddrWidth) - 4;

    // The level counter needs one extra bit so it can represent a completely full FIFO.
    function automatic int unsigned level_w(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // Pointer and level types for the default geometry.
    typedef logic [DefAddrWidth-1:0]          ptr_t;
    typedef logic [level_w(DefAddrWidth)-1:0] level_t;

endpackage

// File: rtl/video_fifo_ram.sv
// Simple dual-port, single-clock RAM with a registered read port.
// The read register only loads when re is high, so it doubles as the
// FIFO output register and holds its word while the consumer stalls.
module video_fifo_ram
    import video_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port; the array is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with synchronous reset of the output register only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/video_fifo.sv
// Single-clock FIFO with valid/ready on both sides, a prefetching output
// register and a registered fill level (RAM words plus output register).
// Define VIDEO_FIFO_ALMOST_EN to add registered almost_full/almost_empty
// outputs and their AF_THRESH / AE_THRESH parameters.
module video_fifo
    import video_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
`ifdef VIDEO_FIFO_ALMOST_EN
    ,
    parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned AE_THRESH  = DefAeThresh
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [level_w(ADDR_WIDTH)-1:0]   level
`ifdef VIDEO_FIFO_ALMOST_EN
    ,
    output logic                             almost_full,
    output logic                             almost_empty
`endif
);

    localparam int unsigned Lw = level_w(ADDR_WIDTH);
    localparam logic [Lw-1:0] LevelFull = Lw'(1 << ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [Lw-1:0]         ram_count_q, ram_count_d;
    logic [Lw-1:0]         level_q, level_d;
    logic                  out_valid_q, out_valid_d;

    logic push, pop, fetch;

    // Handshake decode; in_ready looks only at rst and registered level.
    always_comb begin
        in_ready = !rst && (level_q != LevelFull);
        push     = in_valid && in_ready;
        pop      = out_valid_q && out_ready;
        fetch    = (ram_count_q != '0) && (!out_valid_q || pop);
    end

    // Next-state for pointers, counters and the output-valid flag.
    always_comb begin
        wptr_d      = push  ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
        rptr_d      = fetch ? rptr_q + ADDR_WIDTH'(1) : rptr_q;

        ram_count_d = ram_count_q;
        unique case ({push, fetch})
            2'b10:   ram_count_d = ram_count_q + Lw'(1);
            2'b01:   ram_count_d = ram_count_q - Lw'(1);
            default: ram_count_d = ram_count_q;
        endcase

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + Lw'(1);
            2'b01:   level_d = level_q - Lw'(1);
            default: level_d = level_q;
        endcase

        out_valid_d = out_valid_q;
        if (fetch) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state; reset discards every stored word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_count_q <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_count_q <= ram_count_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
        end
    end

    // The RAM read register is the output register: it loads on fetch only.
    video_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wptr_q),
        .wdata (in_data),
        .re    (fetch),
        .raddr (rptr_q),
        .rdata (out_data)
    );

    assign out_valid = out_valid_q;
    assign level     = level_q;

`ifdef VIDEO_FIFO_ALMOST_EN
    localparam logic [Lw-1:0] AfLevel = Lw'(AF_THRESH);
    localparam logic [Lw-1:0] AeLevel = Lw'(AE_THRESH);

    logic almost_full_q, almost_empty_q;

    // Flags follow the next level so they change on the same edge as level.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (level_d >= AfLevel);
            almost_empty_q <= (level_d <= AeLevel);
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule
